// File: rtl/dct_coef_mem_writer.sv
// dct_coef_mem_writer
// Output-side companion of the 16-point DCT. A row of NCOEF signed coefficients is
// accepted on a valid/ready handshake and written one word per cycle into the
// coefficient SRAM at row*NCOEF+k. Rows are counted per frame; the last write of a
// frame raises a one-cycle frame_done and the row counter wraps to zero.
// Optional feature: define DCT_WR_CHECKSUM_EN to add a 16-bit running checksum
// of the written coefficients, restarted on the first write of every frame.
module dct_coef_mem_writer #(
    parameter int COEF_W = 11,
    parameter int NCOEF  = 16,
    parameter int ROWS   = 512,
    parameter int ADDR_W = 13
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      clr,
    input  logic                      coef_valid,
    input  logic [NCOEF*COEF_W-1:0]   coef_data,
    output logic                      coef_ready,
    output logic                      mem_we,
    output logic [ADDR_W-1:0]         mem_addr,
    output logic [COEF_W-1:0]         mem_wdata,
    output logic                      busy,
    output logic                      frame_done
`ifdef DCT_WR_CHECKSUM_EN
    ,
    output logic [15:0]               checksum
`endif
);

    localparam int IDX_W = (NCOEF > 1) ? $clog2(NCOEF) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCOEF - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_WRITE = 1'b1
    } state_t;

    state_t                           state_q, state_d;
    logic [IDX_W-1:0]                 idx_q, idx_d;
    logic [ROW_W-1:0]                 row_q, row_d;
    logic [NCOEF-1:0][COEF_W-1:0]     buf_q, buf_d;
    logic                             memWe_q, memWe_d;
    logic [ADDR_W-1:0]                memAddr_q, memAddr_d;
    logic [COEF_W-1:0]                memWdata_q, memWdata_d;
    logic                             busy_q, busy_d;
    logic                             frameDone_q, frameDone_d;
`ifdef DCT_WR_CHECKSUM_EN
    logic [15:0]                      checksum_q, checksum_d;
`endif

    logic                             lastWord;
    logic                             accept;
    logic [IDX_W-1:0]                 nextIdx;
    logic [ROW_W-1:0]                 rowAfter;
    logic                             emit;
    logic [IDX_W-1:0]                 emitIdx;
    logic [ROW_W-1:0]                 emitRow;
    logic [COEF_W-1:0]                emitWord;
    logic [ADDR_W-1:0]                emitAddr;

    // Handshake: a new row may enter when idle or while the last word of the current row is on the bus.
    always_comb begin
        lastWord   = (state_q == S_WRITE) && (idx_q == LAST_IDX);
        coef_ready = ((state_q == S_IDLE) || lastWord) && !clr;
        accept     = coef_valid && coef_ready;
        nextIdx    = idx_q + IDX_W'(1);
        rowAfter   = row_q;
        if (lastWord) begin
            rowAfter = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
        end
    end

    // Next-state logic: choose which word (if any) goes on the memory bus next cycle.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        row_d       = row_q;
        buf_d       = buf_q;
        memWe_d     = 1'b0;
        memAddr_d   = memAddr_q;
        memWdata_d  = memWdata_q;
        busy_d      = 1'b0;
        frameDone_d = 1'b0;
`ifdef DCT_WR_CHECKSUM_EN
        checksum_d  = checksum_q;
`endif
        emit        = 1'b0;
        emitIdx     = '0;
        emitRow     = row_q;
        emitWord    = '0;

        if (clr) begin
            state_d = S_IDLE;
            idx_d   = '0;
            row_d   = '0;
`ifdef DCT_WR_CHECKSUM_EN
            checksum_d = '0;
`endif
        end else if (accept) begin
            state_d  = S_WRITE;
            idx_d    = '0;
            row_d    = rowAfter;
            buf_d    = coef_data;
            emit     = 1'b1;
            emitIdx  = '0;
            emitRow  = rowAfter;
            emitWord = coef_data[COEF_W-1:0];
        end else if (state_q == S_WRITE && !lastWord) begin
            idx_d    = nextIdx;
            emit     = 1'b1;
            emitIdx  = nextIdx;
            emitRow  = row_q;
            emitWord = buf_q[nextIdx];
        end else if (lastWord) begin
            state_d = S_IDLE;
            idx_d   = '0;
            row_d   = rowAfter;
        end

        emitAddr = ADDR_W'(emitRow) * ADDR_W'(NCOEF) + ADDR_W'(emitIdx);

        if (emit) begin
            memWe_d     = 1'b1;
            busy_d      = 1'b1;
            memAddr_d   = emitAddr;
            memWdata_d  = emitWord;
            frameDone_d = (emitIdx == LAST_IDX) && (emitRow == LAST_ROW);
`ifdef DCT_WR_CHECKSUM_EN
            if (emitAddr == '0) begin
                checksum_d = 16'($signed(emitWord));
            end else begin
                checksum_d = checksum_q + 16'($signed(emitWord));
            end
`endif
        end
    end

    // State and registered outputs; reset discards any row in flight.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            row_q       <= '0;
            buf_q       <= '0;
            memWe_q     <= 1'b0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            busy_q      <= 1'b0;
            frameDone_q <= 1'b0;
`ifdef DCT_WR_CHECKSUM_EN
            checksum_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            row_q       <= row_d;
            buf_q       <= buf_d;
            memWe_q     <= memWe_d;
            memAddr_q   <= memAddr_d;
            memWdata_q  <= memWdata_d;
            busy_q      <= busy_d;
            frameDone_q <= frameDone_d;
`ifdef DCT_WR_CHECKSUM_EN
            checksum_q  <= checksum_d;
`endif
        end
    end

    assign mem_we     = memWe_q;
    assign mem_addr   = memAddr_q;
    assign mem_wdata  = memWdata_q;
    assign busy       = busy_q;
    assign frame_done = frameDone_q;
`ifdef DCT_WR_CHECKSUM_EN
    assign checksum   = checksum_q;
`endif

endmodule

// File: tb/tb_dct_coef_mem_writer.sv
// tb_dct_coef_mem_writer
// Directed and randomized stimulus for dct_coef_mem_writer. The reference model keeps
// a queue of the memory writes each accepted row must produce; the bus is expected to
// carry the head of that queue every cycle until it drains, and a new row may enter
// only once the queue is empty. Define DCT_WR_CHECKSUM_EN to also check the checksum.
module tb_dct_coef_mem_writer;

    localparam int COEF_W = 11;
    localparam int NCOEF  = 16;
    localparam int ROWS   = 512;
    localparam int ADDR_W = 13;

    typedef struct {
        int unsigned addr;
        int unsigned data;
        bit          fd;
    } wr_t;

    logic                    clk;
    logic                    rstn;
    logic                    clr;
    logic                    coef_valid;
    logic [NCOEF*COEF_W-1:0] coef_data;
    logic                    coef_ready;
    logic                    mem_we;
    logic [ADDR_W-1:0]       mem_addr;
    logic [COEF_W-1:0]       mem_wdata;
    logic                    busy;
    logic                    frame_done;
`ifdef DCT_WR_CHECKSUM_EN
    logic [15:0]             checksum;
`endif

    dct_coef_mem_writer dut (
        .clk        (clk),
        .rstn       (rstn),
        .clr        (clr),
        .coef_valid (coef_valid),
        .coef_data  (coef_data),
        .coef_ready (coef_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef DCT_WR_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    wr_t         expQ[$];
    int          rowCnt = 0;
    int unsigned lastAddr = 0;
    int unsigned lastData = 0;
    int unsigned sum = 0;
    bit          accepted = 0;
    int          fdCount = 0;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned sext16(input int unsigned w);
        logic [10:0] v;
        v = w[10:0];
        return {16'd0, {5{v[10]}}, v};
    endfunction

    task automatic modelReset();
        expQ.delete();
        rowCnt   = 0;
        lastAddr = 0;
        lastData = 0;
        sum      = 0;
    endtask

    // Compare the bus against the model; called just after a falling edge.
    task automatic checkOutput();
        wr_t e;
        if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkVal("mem_we", 32'(mem_we), 32'd1);
            checkVal("busy", 32'(busy), 32'd1);
            checkVal("mem_addr", 32'(mem_addr), e.addr);
            checkVal("mem_wdata", 32'(mem_wdata), e.data);
            checkVal("frame_done", 32'(frame_done), 32'(e.fd));
            lastAddr = e.addr;
            lastData = e.data;
            if (e.addr == 0) sum = sext16(e.data);
            else sum = (sum + sext16(e.data)) & 32'hFFFF;
        end else begin
            checkVal("mem_we_idle", 32'(mem_we), 32'd0);
            checkVal("busy_idle", 32'(busy), 32'd0);
            checkVal("frame_done_idle", 32'(frame_done), 32'd0);
            checkVal("mem_addr_hold", 32'(mem_addr), lastAddr);
            checkVal("mem_wdata_hold", 32'(mem_wdata), lastData);
        end
        if (frame_done === 1'b1) fdCount++;
`ifdef DCT_WR_CHECKSUM_EN
        checkVal("checksum", 32'(checksum), sum);
`endif
    endtask

    // One clock cycle of stimulus; entered and left just after a falling edge.
    task automatic applyStimulus(input logic v, input logic [NCOEF*COEF_W-1:0] d, input logic c);
        bit expReady;
        coef_valid = v;
        coef_data  = d;
        clr        = c;
        #1;
        expReady = (expQ.size() == 0) && !c;
        checkVal("coef_ready", 32'(coef_ready), 32'(expReady));
        @(posedge clk);
        accepted = 0;
        if (c) begin
            expQ.delete();
            rowCnt = 0;
            sum    = 0;
        end else if (v && expReady) begin
            for (int k = 0; k < NCOEF; k++) begin
                wr_t e;
                e.addr = (rowCnt * NCOEF + k) % (1 << ADDR_W);
                e.data = int'(d[k*COEF_W +: COEF_W]);
                e.fd   = (rowCnt == ROWS - 1) && (k == NCOEF - 1);
                expQ.push_back(e);
            end
            rowCnt   = (rowCnt + 1) % ROWS;
            accepted = 1;
        end
        @(negedge clk);
        checkOutput();
    endtask

    task automatic sendRow(input logic [NCOEF*COEF_W-1:0] d);
        int n;
        n = 0;
        do begin
            applyStimulus(1'b1, d, 1'b0);
            n++;
        end while (!accepted && n < 40);
        checkVal("accept_timeout", 32'(accepted), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, '0, 1'b0);
    endtask

    function automatic logic [NCOEF*COEF_W-1:0] randRow();
        logic [NCOEF*COEF_W-1:0] r;
        for (int k = 0; k < NCOEF; k++) r[k*COEF_W +: COEF_W] = 11'($urandom);
        return r;
    endfunction

    logic [NCOEF*COEF_W-1:0] row;

    initial begin
        rstn       = 1'b0;
        clr        = 1'b0;
        coef_valid = 1'b0;
        coef_data  = '0;
        modelReset();

        // Reset state
        @(negedge clk);
        checkVal("rst_mem_we", 32'(mem_we), 32'd0);
        checkVal("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkVal("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        checkVal("rst_busy", 32'(busy), 32'd0);
        checkVal("rst_frame_done", 32'(frame_done), 32'd0);
        checkVal("rst_coef_ready", 32'(coef_ready), 32'd1);
        rstn = 1'b1;
        idle(2);

        // Single row X_k = k+1
        $display("[TB] single row");
        for (int k = 0; k < NCOEF; k++) row[k*COEF_W +: COEF_W] = 11'(k + 1);
        sendRow(row);
        idle(20);

        // Two rows back to back with valid held high
        $display("[TB] back-to-back rows");
        sendRow(randRow());
        sendRow(randRow());
        idle(20);

        // Extreme coefficient values, starting a fresh frame
        $display("[TB] extreme values");
        applyStimulus(1'b0, '0, 1'b1);
        row = '0;
        row[0*COEF_W +: COEF_W] = 11'h7FF;
        row[1*COEF_W +: COEF_W] = 11'h400;
        sendRow(row);
        idle(18);
`ifdef DCT_WR_CHECKSUM_EN
        checkVal("checksum_extreme", 32'(checksum), 32'hFBFF);
`endif

        // Full frame plus one row
        $display("[TB] full frame");
        applyStimulus(1'b0, '0, 1'b1);
        fdCount = 0;
        for (int r = 0; r < ROWS + 1; r++) sendRow(randRow());
        idle(18);
        checkVal("frame_done_pulses", 32'(fdCount), 32'd1);

        // Abort mid-row, then clr together with valid
        $display("[TB] clear");
        sendRow(randRow());
        idle(4);
        applyStimulus(1'b0, '0, 1'b1);
        row = randRow();
        applyStimulus(1'b1, row, 1'b1);
        checkVal("clr_blocks_accept", 32'(accepted), 32'd0);
        sendRow(randRow());
        idle(18);

        // Random traffic with occasional clr
        $display("[TB] random traffic");
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'(($urandom % 3) != 0), randRow(), 1'(($urandom % 50) == 0));
        end
        idle(18);

        // Asynchronous reset in the middle of a row
        $display("[TB] async reset");
        sendRow(randRow());
        idle(3);
        #2;
        rstn = 1'b0;
        #1;
        checkVal("arst_mem_we", 32'(mem_we), 32'd0);
        checkVal("arst_busy", 32'(busy), 32'd0);
        checkVal("arst_mem_addr", 32'(mem_addr), 32'd0);
        checkVal("arst_mem_wdata", 32'(mem_wdata), 32'd0);
        modelReset();
        @(negedge clk);
        checkOutput();
        rstn = 1'b1;
        sendRow(randRow());
        idle(18);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
